// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the instruction-queue entry layout.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] PC_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] PC_HI_DEF      = 32'h0000_6FFC;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

endpackage

// File: rtl/f_instr_queue.sv
// Small synchronous FIFO of fetched instructions with flush and a combinational head.
module f_instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr_reg;
  logic [PW-1:0]  wr_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           enq_ok;
  logic           deq_ok;

  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  assign head   = mem[rd_ptr_reg];
  // When full, a write is only legal because the head leaves on the same edge.
  assign deq_ok = deq && !empty;
  assign enq_ok = enq && (!full || deq_ok);

  always_ff @(posedge clk) begin
    if (enq_ok && !flush) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq_ok, deq_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/f_fetchctrl.sv
// Fetch-stage sequencer: PC register, redirect priority, address fault check, instruction queue.
module f_fetchctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] PC_LO      = PC_LO_DEF,
  parameter logic [31:0] PC_HI      = PC_HI_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter int          QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  input  logic        D_ready,
  output logic        D_valid,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_ExcAdEL,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc
);

  logic [31:0]  pc_reg;
  logic [31:0]  pc_next;
  logic [31:0]  redir_target;
  logic         redir;
  logic         fault;
  logic         deq;
  logic         enq;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_wdata;
  fetch_entry_t q_head;

  assign F_PC  = pc_reg;
  assign fault = (pc_reg[1:0] != 2'b00) || (pc_reg < PC_LO) || (pc_reg > PC_HI);
  assign redir = exc_req || eret_req || br_valid;
  assign deq   = D_valid && D_ready;
  assign enq   = (!q_full || deq) && !redir;

  always_comb begin
    redir_target = br_target;
    if (exc_req)       redir_target = HANDLER_PC;
    else if (eret_req) redir_target = epc;
  end

  always_comb begin
    pc_next = pc_reg;
    if (redir)    pc_next = redir_target;
    else if (enq) pc_next = pc_reg + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_reg <= RESET_PC;
    else        pc_reg <= pc_next;
  end

  // Faulted fetches are still queued so D sees the AdEL on the offending PC.
  always_comb begin
    q_wdata.pc    = pc_reg;
    q_wdata.instr = fault ? 32'h0 : F_Instr;
    q_wdata.adel  = fault;
  end

  f_instr_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .enq   (enq),
    .deq   (deq),
    .flush (redir),
    .wdata (q_wdata),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign D_valid   = !q_empty;
  assign D_Instr   = D_valid ? q_head.instr : 32'h0;
  assign D_PC      = D_valid ? q_head.pc    : 32'h0;
  assign D_ExcAdEL = D_valid && q_head.adel;

endmodule

// File: tb/tb_f_fetchctrl.sv
// Directed per-cycle vector bench for f_fetchctrl against a word-indexed IM model.
module tb_f_fetchctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        D_ready;
  logic        D_valid;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic        D_ExcAdEL;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;

  int tests = 0;
  int failed = 0;

  f_fetchctrl dut (
    .clk       (clk),
    .reset     (reset),
    .F_PC      (F_PC),
    .F_Instr   (F_Instr),
    .D_ready   (D_ready),
    .D_valid   (D_valid),
    .D_Instr   (D_Instr),
    .D_PC      (D_PC),
    .D_ExcAdEL (D_ExcAdEL),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc)
  );

  always #5 clk = ~clk;

  // IM word i holds 0x1111_0000 + i, word 0 at 0x3000.
  assign F_Instr = 32'h1111_0000 + ((F_PC - 32'h0000_3000) >> 2);

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        eret;
    logic [31:0] epc_v;
    logic        chk;
    logic [31:0] e_fpc;
    logic        e_valid;
    logic [31:0] e_dpc;
    logic [31:0] e_instr;
    logic        e_adel;
  } vec_t;

  vec_t vecs [30];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic rdy, input logic br, input logic [31:0] tgt,
                              input logic exc, input logic eret, input logic [31:0] epc_v,
                              input logic chk, input logic [31:0] e_fpc, input logic e_valid,
                              input logic [31:0] e_dpc, input logic [31:0] e_instr, input logic e_adel);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt; v.exc = exc; v.eret = eret; v.epc_v = epc_v;
    v.chk = chk; v.e_fpc = e_fpc; v.e_valid = e_valid; v.e_dpc = e_dpc; v.e_instr = e_instr;
    v.e_adel = e_adel;
    return v;
  endfunction

  task automatic check_outs(input string tag, input int idx, input logic [31:0] fpc, input logic valid,
                            input logic [31:0] dpc, input logic [31:0] instr, input logic adel);
    check({tag, "_F_PC"}, idx, F_PC, fpc);
    check({tag, "_D_valid"}, idx, {31'b0, D_valid}, {31'b0, valid});
    check({tag, "_D_PC"}, idx, D_PC, dpc);
    check({tag, "_D_Instr"}, idx, D_Instr, instr);
    check({tag, "_D_ExcAdEL"}, idx, {31'b0, D_ExcAdEL}, {31'b0, adel});
    $display("[TB] %s %0d: F_PC=%h D_valid=%0b D_PC=%h D_Instr=%h AdEL=%0b",
             tag, idx, F_PC, D_valid, D_PC, D_Instr, D_ExcAdEL);
  endtask

  initial begin
    reset = 1'b0; D_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    // inputs applied during cycle i; expected outputs are those visible in cycle i
    //            rst rdy br tgt            exc eret epc           chk F_PC          val D_PC          D_Instr        adel
    vecs[0]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,         0);
    vecs[1]  = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3000,      0, 32'h0,        32'h0,         0);
    vecs[2]  = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3004,      1, 32'h3000,     32'h1111_0000, 0);
    vecs[3]  = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3008,      1, 32'h3004,     32'h1111_0001, 0);
    vecs[4]  = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h300C,      1, 32'h3008,     32'h1111_0002, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3010,      1, 32'h300C,     32'h1111_0003, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3000,      0, 32'h0,        32'h0,         0);
    vecs[7]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3004,      1, 32'h3000,     32'h1111_0000, 0);
    vecs[8]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3008,      1, 32'h3000,     32'h1111_0000, 0);
    vecs[9]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3008,      1, 32'h3000,     32'h1111_0000, 0);
    vecs[10] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3008,      1, 32'h3000,     32'h1111_0000, 0);
    vecs[11] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3008,      1, 32'h3000,     32'h1111_0000, 0);
    vecs[12] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h300C,      1, 32'h3004,     32'h1111_0001, 0);
    vecs[13] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3010,      1, 32'h3008,     32'h1111_0002, 0);
    vecs[14] = mk(1, 0, 1, 32'h3400,      0, 0, 32'h0,        1, 32'h3010,      1, 32'h3008,     32'h1111_0002, 0);
    vecs[15] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3400,      0, 32'h0,        32'h0,         0);
    vecs[16] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3404,      1, 32'h3400,     32'h1111_0100, 0);
    vecs[17] = mk(1, 1, 1, 32'h3400,      1, 1, 32'h3010,     1, 32'h3408,      1, 32'h3404,     32'h1111_0101, 0);
    vecs[18] = mk(1, 1, 0, 32'h0,         0, 1, 32'h3010,     1, 32'h4180,      0, 32'h0,        32'h0,         0);
    vecs[19] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3010,      0, 32'h0,        32'h0,         0);
    vecs[20] = mk(1, 1, 1, 32'h3002,      0, 0, 32'h0,        1, 32'h3014,      1, 32'h3010,     32'h1111_0004, 0);
    vecs[21] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h3002,      0, 32'h0,        32'h0,         0);
    vecs[22] = mk(1, 1, 1, 32'h7000,      0, 0, 32'h0,        1, 32'h3006,      1, 32'h3002,     32'h0,         1);
    vecs[23] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h7000,      0, 32'h0,        32'h0,         0);
    vecs[24] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h7004,      1, 32'h7000,     32'h0,         1);
    vecs[25] = mk(0, 0, 1, 32'h3400,      0, 0, 32'h0,        1, 32'h7008,      1, 32'h7004,     32'h0,         1);
    vecs[26] = mk(1, 0, 1, 32'h6FFC,      0, 0, 32'h0,        1, 32'h3000,      0, 32'h0,        32'h0,         0);
    vecs[27] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h6FFC,      0, 32'h0,        32'h0,         0);
    vecs[28] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h7000,      1, 32'h6FFC,     32'h1111_0FFF, 0);
    vecs[29] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h7004,      1, 32'h7000,     32'h0,         1);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; D_ready = vecs[i].rdy; br_valid = vecs[i].br; br_target = vecs[i].tgt;
      exc_req = vecs[i].exc; eret_req = vecs[i].eret; epc = vecs[i].epc_v;
      if (vecs[i].chk)
        check_outs("vec", i, vecs[i].e_fpc, vecs[i].e_valid, vecs[i].e_dpc, vecs[i].e_instr, vecs[i].e_adel);
    end

    // PC wrap past 2^32: both the last word and the wrapped address 0 fault
    @(negedge clk);
    reset = 1'b0; br_valid = 1'b0; D_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1; br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
    check_outs("wrap", 0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    br_valid = 1'b0;
    check_outs("wrap", 1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_outs("wrap", 2, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1);
    @(negedge clk);
    check_outs("wrap", 3, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
